calc_unit: RTL

Multicycle execute unit that services the CPU sequencer's SCALC state. It captures operands and opcode when the sequencer enters SCALC and runs single-cycle ALU ops or iterative multiply/divide. It then returns a one-cycle `nxt_line` completion pulse, or a sticky `err`, back to the sequencer. It drives the sequencer's `nxt_line` and `err` inputs.

---
 rtl/calc_unit.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/calc_unit.sv
// calc_unit: multicycle execute unit serving the sequencer's SCALC state.
// Captures opcode/a/b when the sequencer enters SCALC. ALU ops (0-7) finish at
// the capture edge. MUL/DIV/MOD iterate one bit per cycle for W cycles.
// Completion is a one-cycle nxt_line pulse. A bad op raises a sticky err.
//
// Ports:
//   clk       rising-edge clock
//   rstn      synchronous active-low reset
//   q         current sequencer state
//   opcode    operation select, sampled at capture
//   a, b      operands, sampled at capture
//   result    registered result, held until the next completed op
//   ovf       registered overflow/carry/borrow flag, updates with result
//   nxt_line  one-cycle completion pulse
//   err       sticky error level, cleared only by reset
//   busy      high while iterating (RUN)

package seq_pkg;
  typedef enum logic [2:0] {
    SRST    = 3'd0,
    SFETCH  = 3'd1,
    SDECODE = 3'd2,
    SCALC   = 3'd3,
    SWRITE  = 3'd4,
    SERR    = 3'd5
  } SequencerState;
endpackage

// state | meaning
// IDLE  | waiting for entry into SCALC
// RUN   | iterating MUL/DIV/MOD, one bit per cycle
// DONE  | result valid, nxt_line pulsed for this cycle
// ERR   | invalid opcode or divide by zero, held until reset
module calc_unit
  import seq_pkg::*;
#(
  parameter int W = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  SequencerState q,
  input  logic [3:0]    opcode,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  output logic [W-1:0]  result,
  output logic          ovf,
  output logic          nxt_line,
  output logic          err,
  output logic          busy
);

  localparam int SHW = $clog2(W);
  localparam int CW  = $clog2(W + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]      state;
  SequencerState   prev_q;
  logic [3:0]      op_r;
  logic [CW-1:0]   cnt;
  // MUL: acc high = partial product, acc low = remaining multiplier bits.
  // DIV/MOD: acc high = partial remainder, acc low = dividend/quotient bits.
  logic [2*W-1:0]  acc;
  // multiplicand for MUL, divisor for DIV/MOD
  logic [W-1:0]    opnd;

  logic [W-1:0]    alu_res;
  logic            alu_ovf;
  logic [W:0]      sum;
  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      div_part;
  logic [W:0]      div_diff;
  logic [2*W-1:0]  div_next;
  logic [2*W-1:0]  iter_next;
  logic            capture;
  logic            bad_op;

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    sum     = {1'b0, a} + {1'b0, b};
    case (opcode)
      4'd0: begin alu_res = sum[W-1:0]; alu_ovf = sum[W]; end
      4'd1: begin alu_res = a - b;      alu_ovf = (a < b); end
      4'd2: alu_res = a & b;
      4'd3: alu_res = a | b;
      4'd4: alu_res = a ^ b;
      4'd5: alu_res = a << b[SHW-1:0];
      4'd6: alu_res = a >> b[SHW-1:0];
      4'd7: alu_res = b;
      default: ;
    endcase
  end

  always_comb begin
    mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
    mul_next = {mul_sum, acc[W-1:1]};
    // restoring step: shift in next dividend bit, keep the subtraction only if
    // it did not go negative (top bit of the W+1-bit difference clear)
    div_part = acc[2*W-1:W-1];
    div_diff = div_part - {1'b0, opnd};
    div_next = div_diff[W] ? {acc[2*W-2:0], 1'b0}
                           : {div_diff[W-1:0], acc[W-2:0], 1'b1};
    iter_next = (op_r == 4'd8) ? mul_next : div_next;
  end

  assign capture = (state == IDLE) && (q == SCALC) && (prev_q != SCALC);
  assign bad_op  = (opcode > 4'd10) ||
                   (((opcode == 4'd9) || (opcode == 4'd10)) && (b == '0));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= IDLE;
      prev_q <= SRST;
      op_r   <= '0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      result <= '0;
      ovf    <= 1'b0;
    end else begin
      prev_q <= q;
      case (state)
        IDLE: begin
          if (capture) begin
            op_r <= opcode;
            cnt  <= '0;
            if (bad_op) begin
              state <= ERR;
            end else if (opcode <= 4'd7) begin
              result <= alu_res;
              ovf    <= alu_ovf;
              state  <= DONE;
            end else begin
              state <= RUN;
              if (opcode == 4'd8) begin
                acc  <= {{W{1'b0}}, b};
                opnd <= a;
              end else begin
                acc  <= {{W{1'b0}}, a};
                opnd <= b;
              end
            end
          end
        end
        RUN: begin
          if (q != SCALC) begin
            state <= IDLE;
          end else begin
            acc <= iter_next;
            cnt <= cnt + 1'b1;
            if (cnt == CW'(W - 1)) begin
              state <= DONE;
              case (op_r)
                4'd8: begin
                  result <= mul_next[W-1:0];
                  ovf    <= |mul_next[2*W-1:W];
                end
                4'd9: begin
                  result <= div_next[W-1:0];
                  ovf    <= 1'b0;
                end
                default: begin
                  result <= div_next[2*W-1:W];
                  ovf    <= 1'b0;
                end
              endcase
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= ERR;
      endcase
    end
  end

  assign nxt_line = (state == DONE);
  assign err      = (state == ERR);
  assign busy     = (state == RUN);

endmodule
